// File: rtl/op_rr_scheduler_pkg.sv
// ============================================================================
// Module  : pkg
// Brief   : Shared command-channel types and scheduler state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pkg;

    typedef enum logic [7:0] {
        ONE   = 8'd0,
        TWO   = 8'd1,
        THREE = 8'd2
    } enum_t;

    typedef enum_t alias_t;

    typedef struct packed {
        logic [3:0] tag;
        logic [3:0] val;
    } struct_t;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

    localparam enum_t      LOCK_OP      = THREE;
    localparam logic [7:0] OP_MAX_LEGAL = 8'd2;

    function automatic logic op_is_legal(input logic [7:0] op);
        return op <= OP_MAX_LEGAL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/op_rr_scheduler_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational rotate-priority picker: first valid at/after ptr_i.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    localparam logic [IDX_W:0] C_NUM = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (w_sum >= C_NUM) begin
                w_sum = w_sum - C_NUM;
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!any_o && valid_i[w_cand]) begin
                any_o           = 1'b1;
                grant_o[w_cand] = 1'b1;
                idx_o           = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/op_rr_scheduler.sv
// ============================================================================
// Module  : op_rr_scheduler
// Brief   : Round-robin command scheduler with THREE-initiated locked bursts.
// Revision: 1.0
// ============================================================================
`default_nettype none

module op_rr_scheduler
    import pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LOCK_BEATS = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*8-1:0]       req_op_i,
    input  logic [NUM_REQ*8-1:0]       req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output alias_t                     out_op_o,
    output struct_t                    out_data_o,
    output logic [$clog2(NUM_REQ)-1:0] out_src_o,
    output logic                       err_o,
    output logic                       busy_o
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(LOCK_BEATS);
    localparam logic [IDX_W-1:0]  C_LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [BEAT_W-1:0] C_BEATS_INIT = BEAT_W'(LOCK_BEATS - 1);

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == C_LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    sched_state_t      state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  lock_id_q, lock_id_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic              out_valid_q, out_valid_d;
    alias_t            out_op_q, out_op_d;
    struct_t           out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_src_q, out_src_d;
    logic              err_q, err_d;

    logic               w_slot_free;
    logic [NUM_REQ-1:0] w_pick_valid;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_accept;
    logic [7:0]         w_acc_op;
    logic [7:0]         w_acc_data;
    logic               w_acc_legal;

    assign w_slot_free  = !out_valid_q || out_ready_i;
    // While locked only the lock owner is visible to the picker.
    assign w_pick_valid = (state_q == LOCKED)
                        ? (req_valid_i & (NUM_REQ'(1) << lock_id_q))
                        : req_valid_i;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid_i (w_pick_valid),
        .ptr_i   (ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_pick_idx),
        .any_o   (w_pick_any)
    );

    assign w_accept    = w_slot_free && w_pick_any;
    assign req_ready_o = w_accept ? w_grant : '0;
    assign w_acc_op    = req_op_i[{w_pick_idx, 3'b000} +: 8];
    assign w_acc_data  = req_data_i[{w_pick_idx, 3'b000} +: 8];
    assign w_acc_legal = op_is_legal(w_acc_op);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_id_d   = lock_id_q;
        beats_d     = beats_q;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        err_d       = w_accept && !w_acc_legal;

        // Illegal opcodes are consumed but never occupy the slot.
        if (w_accept && w_acc_legal) begin
            out_valid_d = 1'b1;
            out_op_d    = alias_t'(w_acc_op);
            out_data_d  = struct_t'(w_acc_data);
            out_src_d   = w_pick_idx;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ARB: begin
                if (w_accept) begin
                    if (w_acc_op == LOCK_OP) begin
                        state_d   = LOCKED;
                        lock_id_d = w_pick_idx;
                        beats_d   = C_BEATS_INIT;
                    end else begin
                        ptr_d = next_idx(w_pick_idx);
                    end
                end
            end
            LOCKED: begin
                if (w_accept) begin
                    beats_d = beats_q - BEAT_W'(1);
                    if (beats_q == BEAT_W'(1)) begin
                        state_d = ARB;
                        ptr_d   = next_idx(lock_id_q);
                    end
                end else if (w_slot_free && !req_valid_i[lock_id_q]) begin
                    state_d = ARB;
                    ptr_d   = next_idx(lock_id_q);
                    beats_d = '0;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            lock_id_q   <= '0;
            beats_q     <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= ONE;
            out_data_q  <= '0;
            out_src_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_id_q   <= lock_id_d;
            beats_q     <= beats_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            err_q       <= err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_op_o    = out_op_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_op_rr_scheduler.sv
// ============================================================================
// Module  : tb_op_rr_scheduler
// Brief   : Directed scoreboard bench for op_rr_scheduler (4 requesters, 3-beat lock).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_op_rr_scheduler;

    typedef struct {
        logic [1:0] src;
        logic [7:0] op;
        logic [7:0] data;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [31:0]  req_op;
    logic [31:0]  req_data;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic         out_ready;
    pkg::alias_t  out_op;
    pkg::struct_t out_data;
    logic [1:0]   out_src;
    logic         err;
    logic         busy;

    logic [7:0] op_v   [4];
    logic [7:0] data_v [4];
    exp_t       sb[$];
    int         n_cmp;
    int         n_mis;

    op_rr_scheduler #(.NUM_REQ(4), .LOCK_BEATS(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_op_i    (req_op),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_op_o    (out_op),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .err_o       (err),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_op   = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_op[8*i +: 8]   = op_v[i];
            req_data[8*i +: 8] = data_v[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".op"},    32'(out_op),    32'(pkg::ONE));
        chk({tag, ".data"},  32'(out_data),  32'd0);
        chk({tag, ".src"},   32'(out_src),   32'd0);
        chk({tag, ".err"},   32'(err),       32'd0);
        chk({tag, ".busy"},  32'(busy),      32'd0);
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic tick(input logic [3:0] exp_rdy, input string tag);
        exp_t e;
        int   gi;
        #2;
        chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({tag, ".out_src"},  32'(out_src),  32'(e.src));
                chk({tag, ".out_op"},   32'(out_op),   32'(e.op));
                chk({tag, ".out_data"}, 32'(out_data), 32'(e.data));
            end
        end
        if (exp_rdy != 4'b0000) begin
            gi = 0;
            for (int i = 0; i < 4; i++) begin
                if (exp_rdy[i]) gi = i;
            end
            if (op_v[gi] <= 8'd2) begin
                e.src  = 2'(gi);
                e.op   = op_v[gi];
                e.data = data_v[gi];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_mis     = 0;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            op_v[i]   = 8'(pkg::ONE);
            data_v[i] = 8'h10 + 8'(i);
        end
        #2;
        chk_reset("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Plain round robin, output lags grant by one cycle
        out_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick(4'(1 << (k % 4)), "t1");
            chk("t1.src", 32'(out_src), 32'(k % 4));
            chk("t1.valid", 32'(out_valid), 32'd1);
        end

        // Locked burst from requester 2
        tick(4'b0010, "t2.pre");
        chk("t2.pre.busy", 32'(busy), 32'd0);
        op_v[2] = 8'(pkg::THREE); data_v[2] = 8'h2A;
        tick(4'b0100, "t2.b1");
        chk("t2.b1.busy", 32'(busy), 32'd1);
        chk("t2.b1.src", 32'(out_src), 32'd2);
        op_v[2] = 8'(pkg::TWO); data_v[2] = 8'h2B;
        tick(4'b0100, "t2.b2");
        chk("t2.b2.busy", 32'(busy), 32'd1);
        chk("t2.b2.src", 32'(out_src), 32'd2);
        data_v[2] = 8'h2C;
        tick(4'b0100, "t2.b3");
        chk("t2.b3.busy", 32'(busy), 32'd0);
        chk("t2.b3.src", 32'(out_src), 32'd2);
        op_v[2] = 8'(pkg::ONE);
        tick(4'b1000, "t2.next");
        chk("t2.next.src", 32'(out_src), 32'd3);

        // Backpressure stall
        req_valid = 4'b0010;
        op_v[1] = 8'(pkg::TWO); data_v[1] = 8'hA5;
        tick(4'b0010, "t3.load");
        out_ready = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick(4'b0000, "t3.stall");
            chk("t3.stall.valid", 32'(out_valid), 32'd1);
            chk("t3.stall.op",    32'(out_op),    32'(pkg::TWO));
            chk("t3.stall.data",  32'(out_data),  32'hA5);
            chk("t3.stall.src",   32'(out_src),   32'd1);
        end
        out_ready = 1'b1;
        tick(4'b0100, "t3.release");
        chk("t3.release.src", 32'(out_src), 32'd2);

        // Illegal opcode: consumed, dropped, flagged
        req_valid = 4'b0010;
        op_v[1] = 8'h07;
        tick(4'b0010, "t4.ill");
        chk("t4.ill.valid", 32'(out_valid), 32'd0);
        chk("t4.ill.err",   32'(err),       32'd1);
        req_valid = 4'b1111;
        op_v[1] = 8'(pkg::ONE);
        tick(4'b0100, "t4.after");
        chk("t4.after.err",   32'(err),       32'd0);
        chk("t4.after.valid", 32'(out_valid), 32'd1);

        // Early release of a lock on requester 0
        req_valid = 4'b0001;
        op_v[0] = 8'(pkg::THREE); data_v[0] = 8'h50;
        tick(4'b0001, "t5.lock");
        chk("t5.lock.busy", 32'(busy), 32'd1);
        req_valid = 4'b1111;
        op_v[0] = 8'(pkg::TWO); data_v[0] = 8'h51;
        tick(4'b0001, "t5.beat");
        chk("t5.beat.busy", 32'(busy), 32'd1);
        req_valid = 4'b1110;
        tick(4'b0000, "t5.drop");
        chk("t5.drop.busy",  32'(busy),      32'd0);
        chk("t5.drop.valid", 32'(out_valid), 32'd0);
        op_v[0] = 8'(pkg::ONE);
        tick(4'b0010, "t5.next");
        chk("t5.next.src", 32'(out_src), 32'd1);

        // Asynchronous reset in the middle of a burst
        req_valid = 4'b0100;
        op_v[2] = 8'(pkg::THREE);
        tick(4'b0100, "t6.lock");
        op_v[2] = 8'(pkg::TWO);
        tick(4'b0100, "t6.beat");
        chk("t6.beat.busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("t6.async");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        op_v[2]   = 8'(pkg::ONE);
        tick(4'b0001, "t6.first");
        chk("t6.first.src", 32'(out_src), 32'd0);
        req_valid = 4'b0000;
        tick(4'b0000, "t6.drain");
        chk("t6.drain.valid", 32'(out_valid), 32'd0);
        chk("sb.leftover", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
